// File: rtl/stream_pkg.sv
// Shared widths and mask helpers for the byte-stream blocks.
// Helpers work on a fixed maximum mask width; callers cast in and out.
package stream_pkg;
  localparam int PAYLOAD_WIDTH_DEF = 32;
  localparam int DATA_BYTE_WD_DEF  = PAYLOAD_WIDTH_DEF / 8;
  localparam int MAX_BYTES         = 64;
  localparam int MAX_IDX_W         = $clog2(MAX_BYTES);

  function automatic logic [MAX_BYTES-1:0] lsb_onehot(input logic [MAX_BYTES-1:0] m);
    return m & (~m + MAX_BYTES'(1));
  endfunction

  function automatic logic [MAX_IDX_W-1:0] lsb_index(input logic [MAX_BYTES-1:0] m);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_BYTES - 1; i >= 0; i--)
      if (m[i]) idx = MAX_IDX_W'(i);
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_BYTES-1:0] m);
    return (m != '0) && ((m & (m - MAX_BYTES'(1))) == '0);
  endfunction
endpackage

// File: rtl/stream_byte_downsizer_lsb_onehot_sel.sv
// Lowest-set-bit selector: one-hot, index and "exactly one bit left" flag.
module lsb_onehot_sel
  import stream_pkg::*;
#(
  parameter int DATA_BYTE_WD = DATA_BYTE_WD_DEF,
  parameter int IW           = (DATA_BYTE_WD > 1) ? $clog2(DATA_BYTE_WD) : 1
) (
  input  logic [DATA_BYTE_WD-1:0] i_mask,
  output logic [DATA_BYTE_WD-1:0] o_onehot,
  output logic [IW-1:0]           o_index,
  output logic                    o_single
);
  assign o_onehot = DATA_BYTE_WD'(lsb_onehot(MAX_BYTES'(i_mask)));
  assign o_index  = IW'(lsb_index(MAX_BYTES'(i_mask)));
  assign o_single = is_onehot(MAX_BYTES'(i_mask));
endmodule

// File: rtl/stream_byte_downsizer.sv
// Splits a wide beat with a sparse keep mask into one output byte per cycle,
// lowest kept byte first, with no bubble between consecutive beats.
module stream_byte_downsizer
  import stream_pkg::*;
#(
  parameter int payload_width = PAYLOAD_WIDTH_DEF,
  parameter int DATA_BYTE_WD  = payload_width / 8
) (
  input  logic                     i_hclk,
  input  logic                     i_hrst,
  input  logic                     i_source_valid,
  input  logic [payload_width-1:0] i_source_payload,
  input  logic [DATA_BYTE_WD-1:0]  i_source_keepin,
  input  logic                     i_source_last,
  output logic                     o_source_ready,
  output logic                     o_dest_valid,
  output logic [7:0]               o_dest_payload,
  output logic                     o_dest_last,
  input  logic                     i_dest_ready,
  output logic                     o_null_last
);
  localparam int IW = (DATA_BYTE_WD > 1) ? $clog2(DATA_BYTE_WD) : 1;

  logic                     r_full_q, r_full_d;
  logic [DATA_BYTE_WD-1:0]  rem_q, rem_d;
  logic [payload_width-1:0] data_q, data_d;
  logic                     last_q, last_d;
  logic                     null_last_q, null_last_d;

  logic [DATA_BYTE_WD-1:0]  sel_oh;
  logic [IW-1:0]            sel_idx;
  logic                     sel_single;
  logic                     in_xfer, out_xfer, keep_any;

  lsb_onehot_sel #(.DATA_BYTE_WD(DATA_BYTE_WD), .IW(IW)) u_sel (
    .i_mask  (rem_q),
    .o_onehot(sel_oh),
    .o_index (sel_idx),
    .o_single(sel_single)
  );

  // Ready only looks at held state and downstream ready, never at source valid.
  assign o_source_ready = ~r_full_q | (i_dest_ready & sel_single);
  assign in_xfer        = i_source_valid & o_source_ready;
  assign out_xfer       = r_full_q & i_dest_ready;
  assign keep_any       = |i_source_keepin;

  assign o_dest_valid   = r_full_q;
  assign o_dest_payload = r_full_q ? data_q[{sel_idx, 3'b000} +: 8] : 8'h00;
  assign o_dest_last    = last_q & sel_single;
  assign o_null_last    = null_last_q;

  always_comb begin
    r_full_d    = r_full_q;
    rem_d       = rem_q;
    data_d      = data_q;
    last_d      = last_q;
    null_last_d = in_xfer & ~keep_any & i_source_last;
    if (in_xfer && keep_any) begin
      r_full_d = 1'b1;
      rem_d    = i_source_keepin;
      data_d   = i_source_payload;
      last_d   = i_source_last;
    end else if (out_xfer) begin
      rem_d = rem_q & ~sel_oh;
      if (sel_single) r_full_d = 1'b0;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hrst) begin
    if (i_hrst) begin
      r_full_q    <= 1'b0;
      rem_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      null_last_q <= 1'b0;
    end else begin
      r_full_q    <= r_full_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      last_q      <= last_d;
      null_last_q <= null_last_d;
    end
  end
endmodule

// File: tb/tb_stream_byte_downsizer.sv
// Randomized and directed bench for stream_byte_downsizer against a byte-queue model.
module tb_stream_byte_downsizer;
  localparam int PW = 32;
  localparam int BW = PW / 8;

  logic          i_hclk = 1'b0;
  logic          i_hrst = 1'b1;
  logic          i_source_valid = 1'b0;
  logic [PW-1:0] i_source_payload = '0;
  logic [BW-1:0] i_source_keepin = '0;
  logic          i_source_last = 1'b0;
  logic          o_source_ready, o_dest_valid, o_dest_last, o_null_last;
  logic [7:0]    o_dest_payload;
  logic          i_dest_ready = 1'b1;

  stream_byte_downsizer #(.payload_width(PW)) dut (
    .i_hclk(i_hclk), .i_hrst(i_hrst),
    .i_source_valid(i_source_valid), .i_source_payload(i_source_payload),
    .i_source_keepin(i_source_keepin), .i_source_last(i_source_last),
    .o_source_ready(o_source_ready),
    .o_dest_valid(o_dest_valid), .o_dest_payload(o_dest_payload),
    .o_dest_last(o_dest_last), .i_dest_ready(i_dest_ready),
    .o_null_last(o_null_last)
  );

  always #5 i_hclk = ~i_hclk;

  int n_chk = 0, n_pass = 0, cyc = 0, n_null = 0, xfer_cyc = 0;
  int rdy_mode = 0;
  logic       rdy_pat[$];
  logic [8:0] mq[$];            // {last, byte} still owed by the DUT
  logic [7:0] obs_b[$];
  logic       obs_l[$], obs_r[$];
  int         obs_c[$];
  logic       null_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge i_hclk) cyc <= cyc + 1;

  always @(posedge i_hclk) begin
    #2;
    case (rdy_mode)
      1: i_dest_ready = 1'($urandom_range(0, 1));
      2: i_dest_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      default: i_dest_ready = 1'b1;
    endcase
  end

  // Reference: each accepted beat becomes its kept bytes in ascending lane order.
  always @(negedge i_hclk) begin
    if (i_hrst) begin
      mq.delete();
      null_pend = 1'b0;
    end else begin
      chk("src_ready", o_source_ready, (mq.size() == 0) || (i_dest_ready && mq.size() == 1));
      chk("dst_valid", o_dest_valid, mq.size() != 0);
      chk("null_last", o_null_last, null_pend);
      if (o_null_last) n_null++;
      if (o_dest_valid && mq.size() != 0) begin
        chk("dst_byte", o_dest_payload, mq[0][7:0]);
        chk("dst_last", o_dest_last, mq[0][8]);
      end
      if (o_dest_valid && i_dest_ready) begin
        obs_b.push_back(o_dest_payload);
        obs_l.push_back(o_dest_last);
        obs_r.push_back(o_source_ready);
        obs_c.push_back(cyc);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      null_pend = i_source_valid && o_source_ready && i_source_keepin == '0 && i_source_last;
      if (i_source_valid && o_source_ready) begin
        int cnt, k;
        xfer_cyc = cyc;
        cnt = $countones(i_source_keepin);
        k = 0;
        for (int i = 0; i < BW; i++)
          if (i_source_keepin[i]) begin
            k++;
            mq.push_back({i_source_last && (k == cnt), i_source_payload[8*i +: 8]});
          end
      end
    end
  end

  task automatic send_beat(input logic [PW-1:0] d, input logic [BW-1:0] k, input logic l);
    int n;
    logic acc;
    i_source_valid = 1'b1; i_source_payload = d; i_source_keepin = k; i_source_last = l;
    n = 0;
    do begin
      @(negedge i_hclk); acc = o_source_ready;
      @(posedge i_hclk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    i_source_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_hclk);
    while (o_dest_valid && n < 300) begin @(negedge i_hclk); n++; end
    chk("idle_timeout", n < 300, 1);
    @(posedge i_hclk); #1;
  endtask

  task automatic clr_obs();
    obs_b.delete(); obs_l.delete(); obs_r.delete(); obs_c.delete();
  endtask

  initial begin
    logic [7:0] e4[4];
    int n;
    repeat (2) @(posedge i_hclk);
    #1;
    chk("rst_valid", o_dest_valid, 0);
    chk("rst_payload", o_dest_payload, 0);
    chk("rst_last", o_dest_last, 0);
    chk("rst_null", o_null_last, 0);
    chk("rst_ready", o_source_ready, 1);
    i_hrst = 1'b0;
    @(posedge i_hclk); #1;

    // full beat, one byte per cycle, last only on the top byte
    clr_obs();
    send_beat(32'h44332211, 4'b1111, 1'b1);
    wait_idle();
    e4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("s1_count", obs_b.size(), 4);
    for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
      chk("s1_byte", obs_b[i], e4[i]);
      chk("s1_last", obs_l[i], i == 3);
    end
    if (obs_c.size() == 4) begin
      chk("s1_latency", obs_c[0] - xfer_cyc, 1);
      chk("s1_span", obs_c[3] - obs_c[0], 3);
    end

    // sparse keep
    clr_obs();
    send_beat(32'hDDCCBBAA, 4'b1010, 1'b1);
    wait_idle();
    chk("s2_count", obs_b.size(), 2);
    if (obs_b.size() == 2) begin
      chk("s2_b0", obs_b[0], 8'hBB); chk("s2_l0", obs_l[0], 0);
      chk("s2_b1", obs_b[1], 8'hDD); chk("s2_l1", obs_l[1], 1);
      chk("s2_span", obs_c[1] - obs_c[0], 1);
    end

    // back-to-back beats, no bubble
    clr_obs();
    send_beat(32'h04030201, 4'b1111, 1'b0);
    send_beat(32'h08070605, 4'b1111, 1'b1);
    wait_idle();
    chk("s3_count", obs_b.size(), 8);
    if (obs_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("s3_byte", obs_b[i], 8'(i + 1));
        chk("s3_last", obs_l[i], i == 7);
      end
      chk("s3_span", obs_c[7] - obs_c[0], 7);
      chk("s3_rdy_at_04", obs_r[3], 1);
    end

    // downstream stall 1,0,0,1
    clr_obs();
    rdy_mode = 2;
    send_beat(32'h44332211, 4'b1111, 1'b1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    wait_idle();
    rdy_mode = 0;
    chk("s4_count", obs_b.size(), 4);
    for (int i = 0; i < 4 && i < obs_b.size(); i++) chk("s4_byte", obs_b[i], e4[i]);

    // empty last beat
    clr_obs();
    n_null = 0;
    send_beat(32'hFFFFFFFF, 4'b0000, 1'b1);
    repeat (3) @(posedge i_hclk);
    #1;
    chk("s5_no_bytes", obs_b.size(), 0);
    chk("s5_null_pulses", n_null, 1);

    // reset mid-beat
    clr_obs();
    send_beat(32'h44332211, 4'b1111, 1'b1);
    n = 0;
    while (obs_b.size() < 2 && n < 50) begin @(posedge i_hclk); #1; n++; end
    chk("s6_two_bytes", obs_b.size(), 2);
    i_hrst = 1'b1;
    #1;
    chk("s6_rst_valid", o_dest_valid, 0);
    chk("s6_rst_payload", o_dest_payload, 0);
    chk("s6_rst_ready", o_source_ready, 1);
    repeat (2) @(posedge i_hclk);
    #1;
    i_hrst = 1'b0;
    clr_obs();
    send_beat(32'h000000EE, 4'b0001, 1'b1);
    wait_idle();
    chk("s6_count", obs_b.size(), 1);
    if (obs_b.size() == 1) begin
      chk("s6_byte", obs_b[0], 8'hEE);
      chk("s6_last", obs_l[0], 1);
    end

    // random beats, random backpressure and gaps
    rdy_mode = 1;
    for (int b = 0; b < 300; b++) begin
      send_beat($urandom, BW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge i_hclk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_idle();
    chk("rand_drained", mq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stream_byte_downsizer.md
STREAM_BYTE_DOWNSIZER -- requirements
Module: stream_byte_downsizer

Interface
REQ-001 Parameter payload_width, default 32, is the input stream data width in bits and SHALL be a multiple of 8.
REQ-002 Parameter DATA_BYTE_WD, default payload_width/8, is the input byte-lane count.
REQ-003 Port i_hclk, input, 1 bit, is the single clock; all state is updated on its rising edge.
REQ-004 Port i_hrst, input, 1 bit, is the asynchronous, active-high reset.
REQ-005 Port i_source_valid, input, 1 bit, means the input beat is valid.
REQ-006 Port i_source_payload, input, payload_width bits, carries input data; byte k is bits [8k+7:8k].
REQ-007 Port i_source_keepin, input, DATA_BYTE_WD bits, is the per-byte valid mask, which may be non-contiguous.
REQ-008 Port i_source_last, input, 1 bit, marks the final beat of a packet.
REQ-009 Port o_source_ready, output, 1 bit, means the block accepts the input beat this cycle.
REQ-010 Port o_dest_valid, output, 1 bit, means the output byte is valid.
REQ-011 Port o_dest_payload, output, 8 bits, carries the output byte.
REQ-012 Port o_dest_last, output, 1 bit, marks the final byte of a packet.
REQ-013 Port i_dest_ready, input, 1 bit, is backpressure from downstream.
REQ-014 Port o_null_last, output, 1 bit, is a one-cycle pulse when a last beat with an all-zero keep is dropped.

Function
REQ-015 Input transfer SHALL occur on i_source_valid & o_source_ready; output transfer SHALL occur on o_dest_valid & i_dest_ready.
REQ-016 On an input transfer with a nonzero keep, the block SHALL load a holding register with the payload, last flag and remaining-mask = keepin, and set r_full.
REQ-017 State: EMPTY (r_full=0) and BUSY (r_full=1).
  - EMPTY->BUSY on a transfer with nonzero keep.
  - BUSY->EMPTY on an output transfer of the final remaining byte with no simultaneous input transfer.
  - BUSY->BUSY on reload.
REQ-018 In BUSY, o_dest_valid SHALL be 1 and o_dest_payload SHALL be the byte at the lowest set bit of remaining-mask.
REQ-019 On each output transfer, that bit SHALL be cleared from remaining-mask.
REQ-020 o_dest_last SHALL equal beat_last & (remaining-mask has exactly one bit set).
REQ-021 o_source_ready SHALL be ~r_full | (i_dest_ready & remaining-mask one-hot), so there is no bubble between beats.
REQ-022 o_source_ready SHALL NOT depend combinationally on i_source_valid.
REQ-023 Latency SHALL be exactly one cycle from an input transfer to the first o_dest_valid of that beat.
REQ-024 A beat with keep of N set bits SHALL occupy exactly N output cycles when i_dest_ready is held at 1.
REQ-025 An all-zero-keep beat SHALL be accepted and dropped without changing state.
REQ-026 If that all-zero-keep beat has last=1, o_null_last SHALL pulse in the following cycle.
REQ-027 If the last output byte transfers and a new beat transfers in the same cycle, the new beat SHALL load and o_dest_valid SHALL remain 1.
REQ-028 o_dest_payload and o_dest_last SHALL stay stable while o_dest_valid=1 and i_dest_ready=0.

Reset
REQ-029 While i_hrst=1, the block SHALL hold r_full=0, remaining-mask=0, the holding payload=0 and last=0.
REQ-030 While i_hrst=1, the outputs SHALL be o_dest_valid=0, o_dest_payload=0, o_dest_last=0 and o_null_last=0.
REQ-031 While i_hrst=1, o_source_ready SHALL be 1.
REQ-032 A reset asserted mid-beat SHALL discard the remaining bytes; after release, no byte of the discarded beat SHALL be emitted.

Structure
REQ-033 The default widths and the lowest-set-bit/one-hot helper functions SHALL reside in shared package stream_pkg.
REQ-034 The byte select SHALL be a separate sub-module lsb_onehot_sel.
REQ-035 lsb_onehot_sel SHALL take a DATA_BYTE_WD mask and return a one-hot lowest-bit vector and its index, combinationally.

Verification
REQ-036 Scenario: one beat, payload 0x44332211, keep 4'b1111, last=1, dest ready held -> bytes 0x11, 0x22, 0x33, 0x44 on four consecutive cycles, last only on 0x44.
REQ-037 Scenario: keep 4'b1010, payload 0xDDCCBBAA, last=1 -> bytes 0xBB then 0xDD with last on 0xDD, two cycles.
REQ-038 Scenario: two back-to-back full beats 0x04030201 and 0x08070605, last on the second -> eight bytes 0x01..0x08 in eight consecutive cycles, with o_source_ready=1 in the cycle 0x04 transfers.
REQ-039 Scenario: dest ready toggles 1,0,0,1 during a beat -> the byte is held stable while stalled, and no byte is lost or duplicated.
REQ-040 Scenario: keep 4'b0000 with last=1 -> no o_dest_valid, o_null_last=1 for one cycle, o_source_ready stays 1.
REQ-041 Scenario: i_hrst asserted after the second byte of 0x44332211 -> o_dest_valid falls to 0 immediately; after release, the next beat 0x000000EE with keep 4'b0001 yields only 0xEE with last=1.
